// File: rtl/decode_stage.sv
// Instruction decode: register file with bypass, MIPS-subset decoder,
// immediate extension and a one-deep ID/EX register with handshakes.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  aluOp,
  output logic        mux,
  output logic [31:0] data1,
  output logic [31:0] data2reg,
  output logic [31:0] data2ext,
  output logic [4:0]  dest,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        branch,
  output logic        illegal
);

  logic [31:0] r_rf [32];

  logic        r_valid;
  logic        r_illegal;
  logic [3:0]  r_alu;
  logic        r_mux;
  logic [31:0] r_d1;
  logic [31:0] r_d2;
  logic [31:0] r_ext;
  logic [4:0]  r_dest;
  logic        r_rw;
  logic        r_mr;
  logic        r_mw;
  logic        r_br;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;

  assign w_op  = instr[31:26];
  assign w_rs  = instr[25:21];
  assign w_rt  = instr[20:16];
  assign w_rd  = instr[15:11];
  assign w_fn  = instr[5:0];
  assign w_imm = instr[15:0];

  logic        w_legal;
  logic [3:0]  w_alu;
  logic        w_mux;
  logic        w_sext;
  logic        w_rw;
  logic        w_mr;
  logic        w_mw;
  logic        w_br;
  logic [4:0]  w_dest;
  logic [31:0] w_ext;

  always_comb begin
    w_legal = 1'b1;
    w_alu   = 4'b0000;
    w_mux   = 1'b0;
    w_sext  = 1'b1;
    w_rw    = 1'b0;
    w_mr    = 1'b0;
    w_mw    = 1'b0;
    w_br    = 1'b0;
    w_dest  = w_rt;
    unique case (1'b1)
      (w_op == 6'h00): begin
        w_dest = w_rd;
        w_rw   = 1'b1;
        unique case (1'b1)
          (w_fn == 6'h24): w_alu = 4'b0000;
          (w_fn == 6'h25): w_alu = 4'b0001;
          (w_fn == 6'h20): w_alu = 4'b0010;
          (w_fn == 6'h22): w_alu = 4'b0110;
          (w_fn == 6'h2A): w_alu = 4'b0111;
          (w_fn == 6'h27): w_alu = 4'b1100;
          default: w_legal = 1'b0;
        endcase
      end
      (w_op == 6'h08): begin
        w_alu = 4'b0010;
        w_mux = 1'b1;
        w_rw  = 1'b1;
      end
      (w_op == 6'h0C): begin
        w_alu  = 4'b0000;
        w_sext = 1'b0;
        w_mux  = 1'b1;
        w_rw   = 1'b1;
      end
      (w_op == 6'h0D): begin
        w_alu  = 4'b0001;
        w_sext = 1'b0;
        w_mux  = 1'b1;
        w_rw   = 1'b1;
      end
      (w_op == 6'h23): begin
        w_alu = 4'b0010;
        w_mux = 1'b1;
        w_mr  = 1'b1;
        w_rw  = 1'b1;
      end
      (w_op == 6'h2B): begin
        w_alu = 4'b0010;
        w_mux = 1'b1;
        w_mw  = 1'b1;
      end
      (w_op == 6'h04): begin
        w_alu = 4'b0110;
        w_br  = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_ext = w_sext ? {{16{w_imm[15]}}, w_imm}
                        : {16'h0000, w_imm};

  // Write-through: a same-cycle write to the read address wins
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;

  always_comb begin
    w_rs_val = r_rf[w_rs];
    w_rt_val = r_rf[w_rt];
    if (wb_en && wb_addr == w_rs) w_rs_val = wb_data;
    if (wb_en && wb_addr == w_rt) w_rt_val = wb_data;
    if (w_rs == 5'd0) w_rs_val = '0;
    if (w_rt == 5'd0) w_rt_val = '0;
  end

  logic w_accept;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_alu     <= '0;
      r_mux     <= 1'b0;
      r_d1      <= '0;
      r_d2      <= '0;
      r_ext     <= '0;
      r_dest    <= '0;
      r_rw      <= 1'b0;
      r_mr      <= 1'b0;
      r_mw      <= 1'b0;
      r_br      <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= w_legal;
      r_illegal <= !w_legal;
      if (w_legal) begin
        r_alu  <= w_alu;
        r_mux  <= w_mux;
        r_d1   <= w_rs_val;
        r_d2   <= w_rt_val;
        r_ext  <= w_ext;
        r_dest <= w_dest;
        r_rw   <= w_rw;
        r_mr   <= w_mr;
        r_mw   <= w_mw;
        r_br   <= w_br;
      end
    end else begin
      r_illegal <= 1'b0;
      if (out_ready) r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign illegal   = r_illegal;
  assign aluOp     = r_alu;
  assign mux       = r_mux;
  assign data1     = r_d1;
  assign data2reg  = r_d2;
  assign data2ext  = r_ext;
  assign dest      = r_dest;
  assign regWrite  = r_rw;
  assign memRead   = r_mr;
  assign memWrite  = r_mw;
  assign branch    = r_br;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  aluOp;
  logic        mux;
  logic [31:0] data1;
  logic [31:0] data2reg;
  logic [31:0] data2ext;
  logic [4:0]  dest;
  logic        regWrite;
  logic        memRead;
  logic        memWrite;
  logic        branch;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .out_ready(out_ready), .out_valid(out_valid),
    .aluOp(aluOp), .mux(mux), .data1(data1),
    .data2reg(data2reg), .data2ext(data2ext),
    .dest(dest), .regWrite(regWrite),
    .memRead(memRead), .memWrite(memWrite),
    .branch(branch), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [147:0] got;
    rst_n = 1'b0; instr = '0; in_valid = 0;
    flush = 0; wb_en = 0; wb_addr = '0;
    wb_data = '0; out_ready = 1;
    #1;
    got = {out_valid, illegal, aluOp, mux, data1,
           data2reg, data2ext, dest, regWrite,
           memRead, memWrite, branch, in_ready};
    n_checks++;
    if (got !== {147'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h",
               got, {147'd0, 1'b1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_rtype();
    wb_en = 1; wb_addr = 5'd1; wb_data = 32'h0000000F;
    step();
    wb_addr = 5'd2; wb_data = 32'h00000007;
    step();
    wb_en = 0;
    instr = 32'h00221824; in_valid = 1;
    step();
    n_checks++;
    if ({out_valid, aluOp, data1, data2reg, mux, dest, regWrite}
        !== {1'b1, 4'b0000, 32'hF, 32'h7, 1'b0, 5'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL rtype_and v=%b op=%b d1=%h d2=%h m=%b dst=%0d rw=%b exp 1 0000 f 7 0 3 1",
               out_valid, aluOp, data1, data2reg, mux, dest, regWrite);
    end
  endtask

  task automatic test_itype();
    logic [31:0] iv  [6];
    logic [3:0]  eop [6];
    logic [4:0]  efl [6];
    logic [31:0] eex [6];
    iv[0] = 32'h2024FFFF; eop[0] = 4'b0010;
    efl[0] = 5'b11000; eex[0] = 32'hFFFFFFFF;
    iv[1] = 32'h34248000; eop[1] = 4'b0001;
    efl[1] = 5'b11000; eex[1] = 32'h00008000;
    iv[2] = 32'h3024FFFF; eop[2] = 4'b0000;
    efl[2] = 5'b11000; eex[2] = 32'h0000FFFF;
    iv[3] = 32'h8C220004; eop[3] = 4'b0010;
    efl[3] = 5'b11100; eex[3] = 32'h00000004;
    iv[4] = 32'hAC22FFFC; eop[4] = 4'b0010;
    efl[4] = 5'b10010; eex[4] = 32'hFFFFFFFC;
    iv[5] = 32'h1022FFFF; eop[5] = 4'b0110;
    efl[5] = 5'b00001; eex[5] = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      instr = iv[i]; in_valid = 1;
      step();
      n_checks++;
      if ({out_valid, aluOp, mux, regWrite, memRead,
           memWrite, branch, data2ext, data1,
           dest}
          !== {1'b1, eop[i], efl[i], eex[i], 32'hF,
               iv[i][20:16]}) begin
        n_fail++;
        $display("FAIL itype_%0d v=%b op=%b m/rw/mr/mw/br=%b%b%b%b%b ext=%h d1=%h dst=%0d exp op=%b fl=%b ext=%h",
                 i, out_valid, aluOp, mux, regWrite, memRead,
                 memWrite, branch, data2ext, data1, dest,
                 eop[i], efl[i], eex[i]);
      end
    end
    instr = 32'h34248000;
    step();
  endtask

  task automatic test_stall();
    out_ready = 0;
    instr = 32'h00221824; in_valid = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if ({in_ready, out_valid, aluOp, data2ext, dest}
          !== {1'b0, 1'b1, 4'b0001, 32'h00008000, 5'd4}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d rdy=%b v=%b op=%b ext=%h dst=%0d exp 0 1 0001 00008000 4",
                 c, in_ready, out_valid, aluOp, data2ext, dest);
      end
    end
    out_ready = 1;
    step();
    n_checks++;
    if ({out_valid, aluOp, dest} !== {1'b1, 4'b0000, 5'd3}) begin
      n_fail++;
      $display("FAIL b2b_first v=%b op=%b dst=%0d exp 1 0000 3",
               out_valid, aluOp, dest);
    end
    instr = 32'h2024FFFF;
    step();
    n_checks++;
    if ({out_valid, aluOp, dest} !== {1'b1, 4'b0010, 5'd4}) begin
      n_fail++;
      $display("FAIL b2b_second v=%b op=%b dst=%0d exp 1 0010 4",
               out_valid, aluOp, dest);
    end
  endtask

  task automatic test_bypass();
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    instr = 32'h00A03022; in_valid = 1;
    step();
    n_checks++;
    if ({out_valid, aluOp, data1, data2reg, dest}
        !== {1'b1, 4'b0110, 32'hDEADBEEF, 32'h0, 5'd6}) begin
      n_fail++;
      $display("FAIL bypass d1=%h d2=%h op=%b dst=%0d exp deadbeef 0 0110 6",
               data1, data2reg, aluOp, dest);
    end
    wb_en = 0;
    step();
    n_checks++;
    if (data1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL stored_r5 got=%h exp=deadbeef", data1);
    end
    wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    instr = 32'h00002020;
    step();
    n_checks++;
    if ({data1, data2reg} !== 64'h0) begin
      n_fail++;
      $display("FAIL r0_same_cycle d1=%h d2=%h exp 0 0",
               data1, data2reg);
    end
    wb_en = 0;
    step();
    n_checks++;
    if ({out_valid, data1, data2reg} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL r0_readback v=%b d1=%h d2=%h exp 1 0 0",
               out_valid, data1, data2reg);
    end
  endtask

  task automatic test_illegal();
    instr = 32'hFC000000; in_valid = 1;
    step();
    n_checks++;
    if ({illegal, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL illegal_op ill=%b v=%b exp 1 0",
               illegal, out_valid);
    end
    in_valid = 0;
    step();
    n_checks++;
    if ({illegal, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_pulse ill=%b v=%b exp 0 0",
               illegal, out_valid);
    end
    instr = 32'h00000001; in_valid = 1;
    step();
    n_checks++;
    if ({illegal, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL illegal_funct ill=%b v=%b exp 1 0",
               illegal, out_valid);
    end
    instr = 32'h00221824;
    step();
    out_ready = 0; flush = 1;
    instr = 32'hFC000000;
    step();
    n_checks++;
    if ({illegal, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush ill=%b v=%b exp 0 0",
               illegal, out_valid);
    end
    flush = 0; out_ready = 1; in_valid = 0;
    step();
  endtask

  task automatic test_async_reset();
    logic [146:0] got;
    instr = 32'h00221824; in_valid = 1;
    step();
    in_valid = 0; out_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    got = {out_valid, illegal, aluOp, mux, data1,
           data2reg, data2ext, dest, regWrite,
           memRead, memWrite, branch};
    n_checks++;
    if (got !== 147'd0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    instr = 32'h00221824; in_valid = 1; out_ready = 1;
    step();
    n_checks++;
    if ({out_valid, data1, data2reg} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL post_reset_rf v=%b d1=%h d2=%h exp 1 0 0",
               out_valid, data1, data2reg);
    end
    in_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_stall();
    test_bypass();
    test_illegal();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage: sits directly upstream of the `alu` block and produces its `aluOp`, `data1`, `data2reg`, `data2ext` and `mux` inputs. It holds the 32×32 register file (with a write-back port and write-through bypass), decodes a MIPS-subset instruction word and sign/zero-extends the immediate. Results go into a one-deep ID/EX output register with valid/ready handshakes on both sides and a flush input.

## Interface
- Parameters: none. Widths are fixed: 32-bit data, 5-bit register address.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset: asynchronous, active-low.
- `instr`  in  32  Instruction word.
- `in_valid`  in  1  `instr` is valid.
- `in_ready`  out  1  Stage can accept `instr`.
- `flush`  in  1  Discard the held entry and the incoming instruction.
- `wb_en`  in  1  Register-file write enable.
- `wb_addr`  in  5  Write address.
- `wb_data`  in  32  Write data.
- `out_ready`  in  1  Downstream accepts the output entry.
- `out_valid`  out  1  Output entry is valid.
- `aluOp`  out  4  ALU operation code.
- `mux`  out  1  ALU operand select: 0 = `data2reg`, 1 = `data2ext`.
- `data1`  out  32  Value of register rs.
- `data2reg`  out  32  Value of register rt.
- `data2ext`  out  32  Extended immediate.
- `dest`  out  5  Destination register.
- `regWrite`, `memRead`, `memWrite`, `branch`  out  1 each  Control flags.
- `illegal`  out  1  One-cycle pulse when an undecodable instruction is accepted.

## Operation
- Instruction fields:
  - opcode = `instr[31:26]`, rs = `[25:21]`, rt = `[20:16]`, rd = `[15:11]`, funct = `[5:0]`, imm = `[15:0]`.
- R-type (opcode 0x00): `mux`=0, `dest`=rd, `regWrite`=1. funct maps to `aluOp` as follows:
  - 0x24 AND → 0000
  - 0x25 OR → 0001
  - 0x20 ADD → 0010
  - 0x22 SUB → 0110
  - 0x2A SLT → 0111
  - 0x27 NOR → 1100
- I-type, all with `dest`=rt:
  - addi 0x08: `aluOp` 0010, sign-extend, `mux`=1, `regWrite`=1.
  - andi 0x0C: `aluOp` 0000, zero-extend, `mux`=1, `regWrite`=1.
  - ori 0x0D: `aluOp` 0001, zero-extend, `mux`=1, `regWrite`=1.
  - lw 0x23: `aluOp` 0010, sign-extend, `mux`=1, `memRead`=1, `regWrite`=1.
  - sw 0x2B: `aluOp` 0010, sign-extend, `mux`=1, `memWrite`=1.
  - beq 0x04: `aluOp` 0110, sign-extend, `mux`=0, `branch`=1.
- Any other opcode, or an R-type funct not listed, is illegal:
  - The accepted instruction produces no entry (`out_valid` stays 0 for it).
  - `illegal` pulses high for the next cycle.
- Register file:
  - Register 0 always reads 0; writes to it are ignored.
  - Writes are synchronous when `wb_en`=1.
  - Bypass: a read of address A in the same cycle as a write to A (A≠0) returns `wb_data`.
- Handshake:
  - `in_ready` = !`out_valid` | `out_ready` (combinational).
  - An accept occurs when `in_valid` & `in_ready` & !`flush`. The decoded result then loads on that edge.
  - When `out_valid` & `out_ready` with no accept, `out_valid` clears.
  - While `out_valid` & !`out_ready`, every output is held stable.
- Flush has priority over everything else: on the next edge `out_valid`=0, no load occurs, and no `illegal` pulse is raised. Register-file writes are still performed.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle when `out_ready`=1.
- Reset (asynchronous, on `rst_n`=0): every output register and all 32 registers clear to 0. That gives `out_valid`=0, `illegal`=0, `aluOp`=0000, and all data and flags 0.
- Releasing reset mid-stream: the first accept is possible on the first edge after `rst_n` rises.
- Simultaneous pop and accept: the new entry replaces the old one with no bubble.
- Simultaneous write-back and decode of the same register: the bypassed value is captured.

## Test plan
- Reset, then `wb_en` writes r1=0x0000000F and r2=0x00000007. Accept R-type AND r3,r1,r2 (0x00221824) → next cycle `out_valid`=1, `aluOp`=0000, `data1`=0xF, `data2reg`=0x7, `mux`=0, `dest`=3, `regWrite`=1.
- Accept addi r4,r1,-1 (0x2024FFFF) → `data2ext`=0xFFFFFFFF, `mux`=1, `aluOp`=0010. Accept ori r4,r1,0x8000 (0x34248000) → `data2ext`=0x00008000.
- `out_ready`=0 while an entry is held → `in_ready`=0 and outputs are unchanged for 3 cycles. Raising `out_ready` with `in_valid` high → back-to-back entries with no bubble.
- In the same cycle, write r5=0xDEADBEEF and decode sub r6,r5,r0 (0x00A03022) → `data1`=0xDEADBEEF, `data2reg`=0. A write to r0 reads back as 0.
- Accept opcode 0x3F → `illegal`=1 for exactly one cycle and `out_valid`=0. `flush` asserted with `in_valid`=1 → `out_valid`=0 next cycle and no `illegal` pulse.
- Assert `rst_n`=0 asynchronously mid-stream → all outputs are 0 immediately, and previously written registers read 0 afterwards.
